uart_tx_engine: RTL and testbench

Parametrised UART transmit path: write-side FIFO, frame formatter and bit serialiser in one block.
Generalises the fixed 8N1 transmit controller:
- configurable data width, FIFO depth and stop bits;
- runtime parity selection;
- valid/ready write handshake, FIFO level and overflow reporting;
- back-to-back frames with no idle gap.
Sits between the CPU-side UART register interface and the TX pin, paced by the shared baud tick `bclk`.

---
 rtl/uart_tx_if.sv | 11 +
 rtl/uart_tx_engine.sv | 173 +++++++++++++++++
 tb/tb_uart_tx_engine.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_if.sv
// Write-side handshake bundle for the UART transmit engine.
interface uart_tx_if #(
    parameter int unsigned DATA_W = 8
);
    logic [DATA_W-1:0] din;
    logic              din_vld;
    logic              din_rdy;

    modport master (output din, output din_vld, input din_rdy);
    modport slave  (input din, input din_vld, output din_rdy);
endinterface

// File: rtl/uart_tx_engine.sv
// UART transmit path: write FIFO, frame formatter and LSB-first serialiser paced by bclk.
// Optional macro UART_TX_CTS_EN adds the active-low cts_n flow-control input.
module uart_tx_engine #(
    parameter  int unsigned DATA_W     = 8,
    parameter  int unsigned FIFO_DEPTH = 16,
    parameter  int unsigned STOP_BITS  = 1,
    localparam int unsigned LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bclk,
    uart_tx_if.slave         wr,
    input  logic [1:0]       parity_mode,
`ifdef UART_TX_CTS_EN
    input  logic             cts_n,
`endif
    output logic             tx,
    output logic             tx_busy,
    output logic [LVL_W-1:0] fifo_level,
    output logic             ovf
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(DATA_W);

    typedef enum logic [2:0] {IDLE, ARM, START, DATA, PARITY, STOP} state_t;

    state_t            state;
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [LVL_W-1:0]  level_next;
    logic [DATA_W-1:0] head;
    logic [DATA_W-1:0] shreg;
    logic [CW-1:0]     bit_cnt;
    logic              stop_cnt;
    logic              par_en;
    logic              par_bit;
    logic              wr_c;
    logic              pop_c;
    logic              last_stop_c;
    logic              to_idle_c;
    logic              cts_ok_c;

`ifdef UART_TX_CTS_EN
    assign cts_ok_c = !cts_n;
`else
    assign cts_ok_c = 1'b1;
`endif

    // Handshake, pop and occupancy decisions for this cycle.
    always_comb begin
        head        = mem[rd_ptr];
        wr_c        = wr.din_vld && wr.din_rdy;
        last_stop_c = (state == STOP) && bclk && (stop_cnt == 1'(STOP_BITS - 1));
        pop_c       = (fifo_level != '0) && ((state == IDLE) || last_stop_c);
        to_idle_c   = last_stop_c && (fifo_level == '0);
        level_next  = fifo_level + LVL_W'(wr_c) - LVL_W'(pop_c);
    end

    always_ff @(posedge clk) begin
        if (!rst && wr_c) begin
            mem[wr_ptr] <= wr.din;
        end
    end

    // din_rdy is registered from the next level, so a same-cycle pop never frees a full slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            wr.din_rdy <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            if (wr_c) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            fifo_level <= level_next;
            wr.din_rdy <= (level_next != LVL_W'(FIFO_DEPTH));
            if (wr.din_vld && !wr.din_rdy) begin
                ovf <= 1'b1;
            end
        end
    end

    // Frame sequencer; parity mode and parity bit are captured at pop time.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            tx       <= 1'b1;
            tx_busy  <= 1'b0;
            shreg    <= '0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            par_en   <= 1'b0;
            par_bit  <= 1'b0;
        end else begin
            tx_busy <= ((state != IDLE) && !to_idle_c) || pop_c || (level_next != '0);
            if (pop_c) begin
                shreg   <= head;
                par_en  <= ^parity_mode;
                par_bit <= (parity_mode == 2'b10) ? ~^head : ^head;
            end
            case (state)
                IDLE: begin
                    if (pop_c) begin
                        state <= ARM;
                    end
                end
                ARM: begin
                    if (bclk && cts_ok_c) begin
                        tx    <= 1'b0;
                        state <= START;
                    end
                end
                START: begin
                    if (bclk) begin
                        tx      <= shreg[0];
                        shreg   <= shreg >> 1;
                        bit_cnt <= '0;
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (bclk) begin
                        if (bit_cnt == CW'(DATA_W - 1)) begin
                            if (par_en) begin
                                tx    <= par_bit;
                                state <= PARITY;
                            end else begin
                                tx       <= 1'b1;
                                stop_cnt <= 1'b0;
                                state    <= STOP;
                            end
                        end else begin
                            tx      <= shreg[0];
                            shreg   <= shreg >> 1;
                            bit_cnt <= bit_cnt + CW'(1);
                        end
                    end
                end
                PARITY: begin
                    if (bclk) begin
                        tx       <= 1'b1;
                        stop_cnt <= 1'b0;
                        state    <= STOP;
                    end
                end
                STOP: begin
                    if (bclk) begin
                        if (!last_stop_c) begin
                            stop_cnt <= 1'b1;
                        end else if (pop_c) begin
                            // Back-to-back: the tick ending the stop period starts the next frame.
                            if (cts_ok_c) begin
                                tx    <= 1'b0;
                                state <= START;
                            end else begin
                                state <= ARM;
                            end
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_engine.sv
// Directed self-checking bench: default instance plus a DATA_W=7/FIFO_DEPTH=4/STOP_BITS=2 instance.
module tb_uart_tx_engine;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic       rst_a, bclk_a, tx_a, busy_a, ovf_a;
    logic [1:0] pm_a;
    logic [4:0] lvl_a;
    logic       rst_b, bclk_b, tx_b, busy_b, ovf_b;
    logic [1:0] pm_b;
    logic [2:0] lvl_b;

    uart_tx_if #(.DATA_W(8)) if_a ();
    uart_tx_if #(.DATA_W(7)) if_b ();

    uart_tx_engine #(.DATA_W(8), .FIFO_DEPTH(16), .STOP_BITS(1)) dut_a (
        .clk(clk), .rst(rst_a), .bclk(bclk_a), .wr(if_a), .parity_mode(pm_a),
`ifdef UART_TX_CTS_EN
        .cts_n(1'b0),
`endif
        .tx(tx_a), .tx_busy(busy_a), .fifo_level(lvl_a), .ovf(ovf_a)
    );

    uart_tx_engine #(.DATA_W(7), .FIFO_DEPTH(4), .STOP_BITS(2)) dut_b (
        .clk(clk), .rst(rst_b), .bclk(bclk_b), .wr(if_b), .parity_mode(pm_b),
`ifdef UART_TX_CTS_EN
        .cts_n(1'b0),
`endif
        .tx(tx_b), .tx_busy(busy_b), .fifo_level(lvl_b), .ovf(ovf_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic btick(input int u);
        if (u == 0) bclk_a = 1'b1;
        else        bclk_b = 1'b1;
        cyc(1);
        bclk_a = 1'b0;
        bclk_b = 1'b0;
    endtask

    function automatic logic txo(input int u);
        return (u == 0) ? tx_a : tx_b;
    endfunction

    // One bit period = 15 quiet cycles then a bclk cycle; tx must hold, then show the next bit.
    task automatic frame(input int u, input logic [31:0] bits, input int n, input string tag);
        logic prev;
        prev = 1'b1;
        for (int i = 0; i < n; i++) begin
            cyc(15);
            chk($sformatf("%s_hold%0d", tag, i), 32'(txo(u)), 32'(prev));
            btick(u);
            chk($sformatf("%s_bit%0d", tag, i), 32'(txo(u)), 32'(bits[i]));
            prev = bits[i];
        end
    endtask

    task automatic wr_a(input logic [7:0] d);
        if_a.din     = d;
        if_a.din_vld = 1'b1;
        cyc(1);
        if_a.din_vld = 1'b0;
    endtask

    task automatic end_stop(input int u, input string tag);
        cyc(15);
        btick(u);
        chk({tag, "_busy"}, 32'((u == 0) ? busy_a : busy_b), 32'(0));
        chk({tag, "_tx"}, 32'(txo(u)), 32'(1));
    endtask

    initial begin
        rst_a = 1'b1; rst_b = 1'b1; bclk_a = 1'b0; bclk_b = 1'b0;
        pm_a = 2'b00; pm_b = 2'b00;
        if_a.din = '0; if_a.din_vld = 1'b0;
        if_b.din = '0; if_b.din_vld = 1'b0;
        cyc(3);
        chk("rst_tx_a", 32'(tx_a), 32'(1));
        chk("rst_busy_a", 32'(busy_a), 32'(0));
        chk("rst_lvl_a", 32'(lvl_a), 32'(0));
        chk("rst_ovf_a", 32'(ovf_a), 32'(0));
        chk("rst_rdy_a", 32'(if_a.din_rdy), 32'(0));
        chk("rst_rdy_b", 32'(if_b.din_rdy), 32'(0));
        rst_a = 1'b0; rst_b = 1'b0;
        cyc(1);
        chk("rel_rdy_a", 32'(if_a.din_rdy), 32'(1));
        chk("rel_rdy_b", 32'(if_b.din_rdy), 32'(1));

        // 8N1 frame of 0xA5
        wr_a(8'hA5);
        chk("a5_lvl1", 32'(lvl_a), 32'(1));
        chk("a5_busy", 32'(busy_a), 32'(1));
        cyc(1);
        chk("a5_lvl0", 32'(lvl_a), 32'(0));
        frame(0, 32'({1'b1, 8'hA5, 1'b0}), 10, "a5");
        chk("a5_busy_stop", 32'(busy_a), 32'(1));
        end_stop(0, "a5_end");

        // Even parity, mode flipped to odd after the pop
        pm_a = 2'b01;
        wr_a(8'hA5);
        cyc(2);
        pm_a = 2'b10;
        frame(0, 32'({1'b1, 1'b0, 8'hA5, 1'b0}), 11, "even");
        end_stop(0, "even_end");

        // Odd parity, mode flipped to even after the pop
        wr_a(8'hA5);
        cyc(2);
        pm_a = 2'b01;
        frame(0, 32'({1'b1, 1'b1, 8'hA5, 1'b0}), 11, "odd");
        end_stop(0, "odd_end");
        pm_a = 2'b00;

        // Three back-to-back frames
        if_a.din_vld = 1'b1;
        if_a.din = 8'h01; cyc(1);
        chk("b2b_lvl_w1", 32'(lvl_a), 32'(1));
        if_a.din = 8'h02; cyc(1);
        chk("b2b_lvl_w2", 32'(lvl_a), 32'(1));
        if_a.din = 8'h03; cyc(1);
        if_a.din_vld = 1'b0;
        chk("b2b_lvl_w3", 32'(lvl_a), 32'(2));
        frame(0, 32'({1'b1, 8'h03, 1'b0, 1'b1, 8'h02, 1'b0, 1'b1, 8'h01, 1'b0}), 30, "b2b");
        end_stop(0, "b2b_end");
        chk("b2b_lvl_end", 32'(lvl_a), 32'(0));

        // Depth-4 FIFO fill with bclk held low
        if_b.din = 7'h11; if_b.din_vld = 1'b1; cyc(1);
        if_b.din_vld = 1'b0; cyc(1);
        chk("fill_pre_lvl", 32'(lvl_b), 32'(0));
        chk("fill_pre_busy", 32'(busy_b), 32'(1));
        for (int i = 0; i < 6; i++) begin
            if_b.din = 7'(i + 1);
            if_b.din_vld = 1'b1;
            cyc(1);
            chk($sformatf("fill_lvl%0d", i), 32'(lvl_b), 32'((i + 1 < 4) ? i + 1 : 4));
            chk($sformatf("fill_rdy%0d", i), 32'(if_b.din_rdy), 32'((i + 1 < 4) ? 1 : 0));
            chk($sformatf("fill_ovf%0d", i), 32'(ovf_b), 32'((i >= 4) ? 1 : 0));
        end
        if_b.din_vld = 1'b0;
        cyc(5);
        chk("fill_ovf_sticky", 32'(ovf_b), 32'(1));
        chk("fill_lvl_hold", 32'(lvl_b), 32'(4));
        chk("fill_tx_idle", 32'(tx_b), 32'(1));

        rst_b = 1'b1; cyc(1);
        chk("rstb_lvl", 32'(lvl_b), 32'(0));
        chk("rstb_ovf", 32'(ovf_b), 32'(0));
        chk("rstb_busy", 32'(busy_b), 32'(0));
        rst_b = 1'b0; cyc(1);
        chk("rstb_rdy", 32'(if_b.din_rdy), 32'(1));

        // DATA_W=7, two stop bits: second frame waits for the second stop period
        if_b.din_vld = 1'b1;
        if_b.din = 7'h7F; cyc(1);
        if_b.din = 7'h00; cyc(1);
        if_b.din_vld = 1'b0;
        frame(1, 32'({1'b1, 1'b1, 7'h00, 1'b0, 1'b1, 1'b1, 7'h7F, 1'b0}), 20, "stop2");
        end_stop(1, "stop2_end");

        // Reset in the middle of data bit 3 with two words queued
        if_a.din_vld = 1'b1;
        if_a.din = 8'h00; cyc(1);
        if_a.din = 8'h55; cyc(1);
        if_a.din = 8'hFF; cyc(1);
        if_a.din_vld = 1'b0;
        chk("mid_lvl", 32'(lvl_a), 32'(2));
        frame(0, 32'h0, 5, "mid");
        cyc(3);
        rst_a = 1'b1; cyc(1);
        chk("mid_rst_tx", 32'(tx_a), 32'(1));
        chk("mid_rst_lvl", 32'(lvl_a), 32'(0));
        chk("mid_rst_ovf", 32'(ovf_a), 32'(0));
        chk("mid_rst_busy", 32'(busy_a), 32'(0));
        rst_a = 1'b0; cyc(1);
        for (int i = 0; i < 12; i++) begin
            cyc(15);
            btick(0);
            chk($sformatf("quiet_tx%0d", i), 32'(tx_a), 32'(1));
            chk($sformatf("quiet_busy%0d", i), 32'(busy_a), 32'(0));
        end
        wr_a(8'h3C);
        frame(0, 32'({1'b1, 8'h3C, 1'b0}), 10, "post");
        end_stop(0, "post_end");
        chk("final_ovf_a", 32'(ovf_a), 32'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
